// File: rtl/bitstream_msg_ctrl_if.sv
// ----------------------------------------------------------------------------
// bitstream_msg_ctrl_if
// Handshake bundle for the bit-to-byte message controller.
//   in_valid / in_ready / in_char          : character stream into the controller
//   out_valid / out_ready / out_byte / out_last : assembled bytes out
// Modports:
//   slave  : controller side (consumes characters, produces bytes)
//   master : environment side (character source and byte consumer)
// ----------------------------------------------------------------------------
interface bitstream_msg_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_char;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_byte;
    logic       out_last;

    modport slave (
        input  in_valid, in_char, out_ready,
        output in_ready, out_valid, out_byte, out_last
    );

    modport master (
        output in_valid, in_char, out_ready,
        input  in_ready, out_valid, out_byte, out_last
    );
endinterface

// File: rtl/bitstream_msg_ctrl.sv
// ----------------------------------------------------------------------------
// bitstream_msg_ctrl
// Assembles ASCII '0'/'1' characters into bytes and frames messages on newline.
//
// Ports:
//   clk        : clock, rising edge
//   reset      : synchronous, active-low reset
//   bus        : bitstream_msg_ctrl_if.slave (character in / byte out handshakes)
//   o_bit_idx  : bits held in the current partial byte
//   o_byte_cnt : bytes emitted in the current message (saturates at MSG_MAX_BYTES)
//   o_err_char : one-cycle pulse, accepted character was not '0', '1' or LF
//   o_overflow : sticky, a bit was dropped because the message is full
//   o_msg_done : one-cycle pulse, newline processed
//
// Optional feature macro: BITSTREAM_MSG_BITREV_EN
//   defined     : first received bit lands in out_byte[7] (MSB first)
//   not defined : first received bit lands in out_byte[0] (LSB first)
// ----------------------------------------------------------------------------
module bitstream_msg_ctrl #(
    parameter int MSG_MAX_BYTES = 16,
    parameter int CNT_W         = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    bitstream_msg_ctrl_if.slave  bus,
    output logic [2:0]           o_bit_idx,
    output logic [CNT_W-1:0]     o_byte_cnt,
    output logic                 o_err_char,
    output logic                 o_overflow,
    output logic                 o_msg_done
);

    typedef enum logic {COLLECT = 1'b0, EMIT = 1'b1} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_shift;
    logic [2:0]       r_bit_idx;
    logic [CNT_W-1:0] r_byte_cnt;
    logic [7:0]       r_out_byte;
    logic             r_out_last;
    logic             r_err_char;
    logic             r_overflow;
    logic             r_msg_done;

    logic             w_accept;
    logic             w_is_bit;
    logic             w_is_nl;
    logic             w_full;
    logic [2:0]       w_pos;
    logic [7:0]       w_shift_set;

    assign w_accept = bus.in_valid && (r_state == COLLECT);
    assign w_is_bit = (bus.in_char == 8'h30) || (bus.in_char == 8'h31);
    assign w_is_nl  = (bus.in_char == 8'h0A);
    assign w_full   = (r_byte_cnt == CNT_W'(MSG_MAX_BYTES));

`ifdef BITSTREAM_MSG_BITREV_EN
    assign w_pos = 3'd7 - r_bit_idx;
`else
    assign w_pos = r_bit_idx;
`endif

    // The shift register is always cleared when a byte leaves, so OR-ing in the
    // new bit is enough; unfilled positions stay zero and form the padding.
    assign w_shift_set = r_shift | ({7'd0, bus.in_char[0]} << w_pos);

    // State register
    always_ff @(posedge clk) begin
        if (!reset) r_state <= COLLECT;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            COLLECT: begin
                if (w_accept && w_is_bit && !w_full && (r_bit_idx == 3'd7))
                    w_state_nxt = EMIT;
                else if (w_accept && w_is_nl && (r_bit_idx != 3'd0))
                    w_state_nxt = EMIT;
            end
            EMIT: begin
                if (bus.out_ready) w_state_nxt = COLLECT;
            end
            default: w_state_nxt = COLLECT;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        bus.in_ready  = (r_state == COLLECT);
        bus.out_valid = (r_state == EMIT);
    end

    // Datapath and status registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_shift    <= 8'h00;
            r_bit_idx  <= 3'd0;
            r_byte_cnt <= '0;
            r_out_byte <= 8'h00;
            r_out_last <= 1'b0;
            r_err_char <= 1'b0;
            r_overflow <= 1'b0;
            r_msg_done <= 1'b0;
        end else begin
            r_err_char <= 1'b0;
            r_msg_done <= 1'b0;
            if (w_accept) begin
                if (w_is_bit) begin
                    if (w_full) begin
                        r_overflow <= 1'b1;
                    end else if (r_bit_idx == 3'd7) begin
                        r_out_byte <= w_shift_set;
                        r_out_last <= 1'b0;
                        r_shift    <= 8'h00;
                        r_bit_idx  <= 3'd0;
                    end else begin
                        r_shift    <= w_shift_set;
                        r_bit_idx  <= r_bit_idx + 3'd1;
                    end
                end else if (w_is_nl) begin
                    if (r_bit_idx != 3'd0) begin
                        r_out_byte <= r_shift;
                        r_out_last <= 1'b1;
                        r_shift    <= 8'h00;
                        r_bit_idx  <= 3'd0;
                    end
                    r_msg_done <= 1'b1;
                    r_byte_cnt <= '0;
                    r_overflow <= 1'b0;
                end else begin
                    r_err_char <= 1'b1;
                end
            end
            if ((r_state == EMIT) && bus.out_ready) begin
                // The closing partial byte belongs to a message the newline has
                // already ended, so its handoff leaves the count at zero.
                if (r_out_last)  r_byte_cnt <= '0;
                else if (!w_full) r_byte_cnt <= r_byte_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.out_byte = r_out_byte;
    assign bus.out_last = r_out_last;
    assign o_bit_idx    = r_bit_idx;
    assign o_byte_cnt   = r_byte_cnt;
    assign o_err_char   = r_err_char;
    assign o_overflow   = r_overflow;
    assign o_msg_done   = r_msg_done;

endmodule

// File: tb/tb_bitstream_msg_ctrl.sv
// ----------------------------------------------------------------------------
// tb_bitstream_msg_ctrl
// Directed bench with a byte scoreboard. The DUT is built with a two-byte
// message limit so the overflow boundary is reachable.
// ----------------------------------------------------------------------------
module tb_bitstream_msg_ctrl;
    localparam int MAXB = 2;
    localparam int CW   = 2;

`ifdef BITSTREAM_MSG_BITREV_EN
    localparam logic [7:0] E_FULL = 8'hB0;
    localparam logic [7:0] E_PART = 8'hC0;
    localparam logic [7:0] E_JUNK = 8'h80;
    localparam logic [7:0] E_OV1  = 8'h80;
    localparam logic [7:0] E_OV2  = 8'h40;
`else
    localparam logic [7:0] E_FULL = 8'h0D;
    localparam logic [7:0] E_PART = 8'h03;
    localparam logic [7:0] E_JUNK = 8'h01;
    localparam logic [7:0] E_OV1  = 8'h01;
    localparam logic [7:0] E_OV2  = 8'h02;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    bit_idx;
    logic [CW-1:0] byte_cnt;
    logic          err_char, overflow, msg_done;

    bitstream_msg_ctrl_if bus();

    bitstream_msg_ctrl #(.MSG_MAX_BYTES(MAXB), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .o_bit_idx  (bit_idx),
        .o_byte_cnt (byte_cnt),
        .o_err_char (err_char),
        .o_overflow (overflow),
        .o_msg_done (msg_done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_hand = 0;
    logic [8:0] sb[$];   // {last, byte}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every handoff is matched against the next expected byte.
    always @(negedge clk) begin
        if (reset === 1'b1 && bus.out_valid && bus.out_ready) begin
            n_hand++;
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL sb_unexpected: got byte 0x%0h last %0d, expected none",
                         bus.out_byte, bus.out_last);
            end else begin
                logic [8:0] e;
                e = sb.pop_front();
                check("sb_byte", 32'(bus.out_byte), 32'(e[7:0]));
                check("sb_last", 32'(bus.out_last), 32'(e[8]));
            end
        end
    end

    task automatic send_char(input logic [7:0] c);
        bit ok = 0;
        bus.in_valid = 1'b1;
        bus.in_char  = c;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                ok = 1;
                break;
            end
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            n_chk++;
            $display("FAIL send_timeout: char 0x%0h not accepted in 50 cycles", c);
        end
    endtask

    task automatic send_bits(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_char   = 8'h00;
        bus.out_ready = 1'b1;
        reset         = 1'b0;
        tick(); tick();
        reset = 1'b1;

        // Reset values
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_byte",  32'(bus.out_byte),  32'd0);
        check("rst_out_last",  32'(bus.out_last),  32'd0);
        check("rst_bit_idx",   32'(bit_idx),       32'd0);
        check("rst_byte_cnt",  32'(byte_cnt),      32'd0);
        check("rst_flags",     32'({err_char, overflow, msg_done}), 32'd0);

        // Reset mid-byte discards the partial byte
        send_bits("11111");
        check("pre_rst_bit_idx", 32'(bit_idx), 32'd5);
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        check("mid_rst_bit_idx",   32'(bit_idx),       32'd0);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);

        // Full byte, consumer always ready
        sb.push_back({1'b0, E_FULL});
        send_bits("10110000");
        check("full_out_valid", 32'(bus.out_valid), 32'd1);
        check("full_in_ready",  32'(bus.in_ready),  32'd0);
        tick();
        check("full_valid_drop", 32'(bus.out_valid), 32'd0);
        check("full_byte_cnt",   32'(byte_cnt),      32'd1);
        send_char(8'h0A);
        check("nl0_msg_done",  32'(msg_done),      32'd1);
        check("nl0_out_valid", 32'(bus.out_valid), 32'd0);
        tick();
        check("nl0_msg_pulse", 32'(msg_done), 32'd0);
        check("nl0_byte_cnt",  32'(byte_cnt), 32'd0);

        // Backpressure
        bus.out_ready = 1'b0;
        sb.push_back({1'b0, 8'hFF});
        send_bits("11111111");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready",  32'(bus.in_ready),  32'd0);
            check("bp_out_byte",  32'(bus.out_byte),  32'hFF);
        end
        tick();
        bus.out_ready = 1'b1;
        tick();
        check("bp_released",  32'(bus.out_valid), 32'd0);
        check("bp_byte_cnt",  32'(byte_cnt),      32'd1);
        send_char(8'h0A);

        // Partial byte closed by newline
        sb.push_back({1'b1, E_PART});
        send_bits("11");
        send_char(8'h0A);
        check("part_msg_done",  32'(msg_done),      32'd1);
        check("part_out_valid", 32'(bus.out_valid), 32'd1);
        check("part_out_last",  32'(bus.out_last),  32'd1);
        tick();
        check("part_valid_drop", 32'(bus.out_valid), 32'd0);
        check("part_byte_cnt",   32'(byte_cnt),      32'd0);
        check("part_bit_idx",    32'(bit_idx),       32'd0);

        // Junk character between bits
        sb.push_back({1'b0, E_JUNK});
        send_char("1");
        send_char(8'h41);
        check("junk_err_char", 32'(err_char), 32'd1);
        check("junk_bit_idx",  32'(bit_idx),  32'd1);
        tick();
        check("junk_err_pulse", 32'(err_char), 32'd0);
        send_bits("0000000");
        tick();
        check("junk_byte_cnt", 32'(byte_cnt), 32'd1);
        send_char(8'h0A);
        tick();

        // Overflow at the two-byte limit
        sb.push_back({1'b0, E_OV1});
        sb.push_back({1'b0, E_OV2});
        send_bits("10000000");
        send_bits("01000000");
        send_bits("11111111");
        tick();
        check("ovf_flag",     32'(overflow),      32'd1);
        check("ovf_bit_idx",  32'(bit_idx),       32'd0);
        check("ovf_byte_cnt", 32'(byte_cnt),      32'd2);
        check("ovf_no_valid", 32'(bus.out_valid), 32'd0);
        send_char(8'h0A);
        check("ovf_nl_done",  32'(msg_done),      32'd1);
        check("ovf_cleared",  32'(overflow),      32'd0);
        check("ovf_nl_valid", 32'(bus.out_valid), 32'd0);
        tick(); tick();

        check("sb_drained",    32'(sb.size()), 32'd0);
        check("handoff_count", 32'(n_hand),    32'd6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
